// File: rtl/clock_factor_detector_pkg.sv
// Shared definitions for the divided-clock factor detector: factor codes, FSM states and the
// period-to-factor decode.
package clock_factor_detector_pkg;

  localparam int unsigned FACTOR_WIDTH = 2;

  localparam logic [FACTOR_WIDTH-1:0] FACTOR_NONE = 2'd0;
  localparam logic [FACTOR_WIDTH-1:0] FACTOR_2    = 2'd1;
  localparam logic [FACTOR_WIDTH-1:0] FACTOR_4    = 2'd2;
  localparam logic [FACTOR_WIDTH-1:0] FACTOR_8    = 2'd3;

  // Wide enough for LOCK_COUNT up to 15.
  localparam int unsigned MATCH_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StTrack,
    StLocked
  } fd_state_e;

  function automatic logic [FACTOR_WIDTH-1:0] factor_of(input int unsigned period);
    case (period)
      2:       return FACTOR_2;
      4:       return FACTOR_4;
      8:       return FACTOR_8;
      default: return FACTOR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_factor_detector_if.sv
// Divided-clock input and measurement results of the factor detector.
interface clock_factor_detector_if #(
  parameter int unsigned COUNT_WIDTH = 8
) ();
  import clock_factor_detector_pkg::*;

  logic                    clock_d;
  logic [COUNT_WIDTH-1:0]  period;
  logic                    period_valid;
  logic                    locked;
  logic [FACTOR_WIDTH-1:0] factor;

  modport master (
    input  clock_d,
    output period,
    output period_valid,
    output locked,
    output factor
  );

  modport slave (
    output clock_d,
    input  period,
    input  period_valid,
    input  locked,
    input  factor
  );

endinterface

// File: rtl/clock_factor_detector_edge_detector.sv
// Registered sample of a synchronous level input plus a combinational rising-edge pulse.
module clock_factor_detector_edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= din;
    end
  end

  assign rise = din & ~d_q;

endmodule

// File: rtl/clock_factor_detector.sv
// Measures the period of a divided clock in system clock cycles, declares lock after a run of
// identical periods and maps the locked period onto a factor code.
module clock_factor_detector
  import clock_factor_detector_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input logic                     clock,
  input logic                     reset,
  clock_factor_detector_if.master bus
);

  localparam logic [COUNT_WIDTH-1:0] CntMax     = '1;
  localparam logic [MATCH_WIDTH-1:0] LockTarget = MATCH_WIDTH'(LOCK_COUNT);
  localparam logic [MATCH_WIDTH-1:0] MatchOne   = MATCH_WIDTH'(1);

  logic                    rise;
  logic                    saturated;
  logic                    same;
  logic [MATCH_WIDTH-1:0]  match_inc;

  logic [COUNT_WIDTH-1:0]  cnt_q;
  logic [COUNT_WIDTH-1:0]  ref_q;
  logic [MATCH_WIDTH-1:0]  match_q;
  fd_state_e               state_q;
  logic [COUNT_WIDTH-1:0]  period_q;
  logic                    period_valid_q;
  logic                    locked_q;
  logic [FACTOR_WIDTH-1:0] factor_q;

  clock_factor_detector_edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .din   (bus.clock_d),
    .rise  (rise)
  );

  // Cycles since the last rise; the value at a rise is the measured period.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= COUNT_WIDTH'(1);
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign saturated = (cnt_q == CntMax);
  // An all-ones period is a timeout artefact, so it never matches.
  assign same      = (cnt_q == ref_q) && !saturated;
  assign match_inc = match_q + MatchOne;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      ref_q          <= '0;
      match_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      factor_q       <= FACTOR_NONE;
    end else begin
      period_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            ref_q          <= cnt_q;
            match_q        <= '0;
            state_q        <= StTrack;
          end else if (saturated) begin
            state_q <= StIdle;
          end
        end
        StTrack, StLocked: begin
          if (rise) begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            if (same) begin
              if (state_q == StTrack) begin
                match_q <= match_inc;
                if (match_inc == LockTarget) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                  factor_q <= factor_of(32'(ref_q));
                end
              end
            end else begin
              ref_q    <= cnt_q;
              match_q  <= '0;
              state_q  <= StTrack;
              locked_q <= 1'b0;
              factor_q <= FACTOR_NONE;
            end
          end else if (saturated) begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
            factor_q <= FACTOR_NONE;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.factor       = factor_q;

endmodule

// File: doc/clock_factor_detector.md
Name: clock_factor_detector

Overview:
- Receive-side companion to clock_divider: takes a divided clock (clock_d) produced from the same `clock` and measures its period in `clock` cycles.
- Reports each measured period, declares lock after a run of identical periods, and maps the locked period onto the `FACTOR_*` codes.
- Used to self-check divider outputs and to let LightIO peripherals confirm which rate they are being fed.

Parameters:
- COUNT_WIDTH, 8, width of the period counter and of the period output; maximum measurable period is 2^COUNT_WIDTH-2.
- LOCK_COUNT, 4, number of consecutive periods equal to the reference period required to assert locked (range 1..15).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clock_d  input  1  divided clock, generated synchronously from clock and treated as data sampled on clock.
- period  output  COUNT_WIDTH  last measured period, in clock cycles.
- period_valid  output  1  one-cycle pulse when period updates.
- locked  output  1  high while the period is stable.
- factor  output  `FACTOR_WIDTH  `FACTOR_2/`FACTOR_4/`FACTOR_8 when locked at period 2/4/8, else `FACTOR_NONE.

Behaviour:
- Reset, synchronous: on a clock edge with reset=1, outputs take these values — period=0, period_valid=0, locked=0, factor=`FACTOR_NONE.
- Reset, internal state: state=IDLE, counter=0, match count=0, clock_d sample register=0.
- Reset mid-operation clears everything at that edge; no period_valid is emitted for the interrupted period.
- Edge detect: d_q <= clock_d every cycle; rise = clock_d & ~d_q.
- Counter on rise: cnt <= 1.
- Counter otherwise: cnt increments, saturating at all-ones.
- Measured period: the value of cnt at a rise. A clock_d of period N cycles yields exactly N; factor 2 yields 2.
- State IDLE: the first rise moves to MEASURE. No output is produced.
- State MEASURE: the next rise captures the reference period, drives period and pulses period_valid, clears the match count, then moves to TRACK.
- State TRACK, rise with measured period == reference: match count increments.
- State TRACK, rise with mismatch: the new period becomes the reference and the match count returns to 0.
- Every rise in TRACK and LOCKED updates period and pulses period_valid.
- TRACK to LOCKED: when the match count reaches LOCK_COUNT, move to LOCKED.
- State LOCKED, matching rise: stay in LOCKED.
- State LOCKED, mismatching rise: go to TRACK with the new reference and match count 0.
- Latency: all outputs are registered. period and period_valid change one cycle after the clock edge where rise is detected. locked and factor change on the same cycle as the period_valid that completes or breaks lock.
- locked: high exactly while state==LOCKED.
- factor: decoded from the reference period while LOCKED; 2/4/8 give the matching code, any other period gives `FACTOR_NONE.
- Timeout: if cnt reaches all-ones in MEASURE, TRACK or LOCKED, go to IDLE the next cycle. This drops locked, sets factor to `FACTOR_NONE, emits no period_valid, and holds period at its last value. A stuck-high or stuck-low clock_d therefore unlocks after 2^COUNT_WIDTH-1 cycles.
- Simultaneous rise and saturation: the rise wins and the period is captured as all-ones. A period of all-ones always counts as a mismatch and never locks.
- Period 1 cannot occur (clock_d cannot rise on consecutive cycles). Duty cycle is ignored; only rising edges matter.

Decomposition:
- Shared definitions.v: existing `FACTOR_2/4/8, plus new `FACTOR_NONE and `FACTOR_WIDTH.
- Shared definitions.v: state encodings `FD_IDLE, `FD_MEASURE, `FD_TRACK, `FD_LOCKED.
- One natural sub-module: edge_detector (registered sample plus rise pulse), reusable by other LightIO input blocks.
- Counter, FSM and factor decode stay in the top module.

Test Plan:
- Drive from clock_divider factor 2 after reset -> period_valid every 2 cycles with period=2; locked=1 and factor=`FACTOR_2 one cycle after the 6th clock_d rise (1 start + 1 reference + 4 matches).
- Factor 8 divider -> period=8 on every pulse, locked after the 6th rise, factor=`FACTOR_8; no period_valid before the 2nd rise.
- Switch the divider from factor 4 to 8 while locked -> first 8-period pulse shows period=8 with locked=0 and factor=`FACTOR_NONE; relock after 4 further 8-periods.
- Custom clock_d with period 3 -> period=3 stream, locked=1, factor=`FACTOR_NONE.
- Hold clock_d low after lock at factor 4 -> locked drops 255 cycles after the last rise, period stays 4, no period_valid.
- Assert reset for 1 cycle while locked -> next cycle all outputs at reset values; relock takes the full 6 rises again.
